// File: rtl/cardinal_nic.sv
// Mesh NIC: single-packet eject buffer and inject buffer, each with a status flag,
// memory-mapped to the processor; injects only on the polarity matching the packet VC bit.
module cardinal_nic #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        addr,
    input  logic [DATA_W-1:0] d_in,
    output logic [DATA_W-1:0] d_out,
    input  logic              nicEn,
    input  logic              nicEnWr,
    input  logic              net_si,
    output logic              net_ri,
    input  logic [DATA_W-1:0] net_di,
    output logic              net_so,
    input  logic              net_ro,
    output logic [DATA_W-1:0] net_do,
    input  logic              net_polarity
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } chan_t;

    chan_t             r_in_st;
    chan_t             r_out_st;
    chan_t             w_in_st_nxt;
    chan_t             w_out_st_nxt;
    logic [DATA_W-1:0] r_ibuf;
    logic [DATA_W-1:0] r_obuf;
    logic [DATA_W-1:0] r_d_out;
    logic [DATA_W-1:0] r_net_do;
    logic              r_net_so;

    logic w_in_full;
    logic w_out_full;
    logic w_rd;
    logic w_wr;
    logic w_eject;
    logic w_rd_ibuf;
    logic w_wr_obuf;
    logic w_inject;

    assign w_in_full  = (r_in_st == FULL);
    assign w_out_full = (r_out_st == FULL);
    assign w_rd       = nicEn & ~nicEnWr;
    assign w_wr       = nicEn & nicEnWr;

    // All events are judged against pre-edge status, so a write colliding with an inject is dropped.
    assign w_eject   = net_si & ~w_in_full;
    assign w_rd_ibuf = w_rd & (addr == 2'b00) & w_in_full;
    assign w_wr_obuf = w_wr & (addr == 2'b10) & ~w_out_full;
    assign w_inject  = w_out_full & net_ro & (net_polarity == r_obuf[DATA_W-1]);

    always_comb begin
        w_in_st_nxt = r_in_st;
        case (r_in_st)
            EMPTY:   if (w_eject)   w_in_st_nxt = FULL;
            FULL:    if (w_rd_ibuf) w_in_st_nxt = EMPTY;
            default: w_in_st_nxt = EMPTY;
        endcase
    end

    always_comb begin
        w_out_st_nxt = r_out_st;
        case (r_out_st)
            EMPTY:   if (w_wr_obuf) w_out_st_nxt = FULL;
            FULL:    if (w_inject)  w_out_st_nxt = EMPTY;
            default: w_out_st_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_in_st  <= EMPTY;
            r_out_st <= EMPTY;
        end else begin
            r_in_st  <= w_in_st_nxt;
            r_out_st <= w_out_st_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ibuf <= '0;
            r_obuf <= '0;
        end else begin
            if (w_eject)   r_ibuf <= net_di;
            if (w_wr_obuf) r_obuf <= d_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_d_out <= '0;
        end else if (w_rd) begin
            case (addr)
                2'b00:   r_d_out <= r_ibuf;
                2'b01:   r_d_out <= {{(DATA_W-1){1'b0}}, w_in_full};
                2'b11:   r_d_out <= {{(DATA_W-1){1'b0}}, w_out_full};
                default: r_d_out <= r_d_out;
            endcase
        end
    end

    // Inject pulse lasts one cycle; net_do keeps the last packet sent.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_net_so <= 1'b0;
            r_net_do <= '0;
        end else begin
            r_net_so <= w_inject;
            if (w_inject) r_net_do <= r_obuf;
        end
    end

    assign d_out  = r_d_out;
    assign net_so = r_net_so;
    assign net_do = r_net_do;
    assign net_ri = ~w_in_full;

endmodule

// File: tb/tb_cardinal_nic.sv
// Bench for cardinal_nic: packet-level reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_cardinal_nic;

    logic        clk;
    logic        reset;
    logic [1:0]  addr;
    logic [63:0] d_in;
    logic [63:0] d_out;
    logic        nicEn;
    logic        nicEnWr;
    logic        net_si;
    logic        net_ri;
    logic [63:0] net_di;
    logic        net_so;
    logic        net_ro;
    logic [63:0] net_do;
    logic        net_polarity;

    cardinal_nic #(.DATA_W(64)) dut (
        .clk          (clk),
        .reset        (reset),
        .addr         (addr),
        .d_in         (d_in),
        .d_out        (d_out),
        .nicEn        (nicEn),
        .nicEnWr      (nicEnWr),
        .net_si       (net_si),
        .net_ri       (net_ri),
        .net_di       (net_di),
        .net_so       (net_so),
        .net_ro       (net_ro),
        .net_do       (net_do),
        .net_polarity (net_polarity)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    bit run_cmp = 0;
    logic pol_edge = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Mesh polarity flips every cycle, settling 1 time unit after the edge.
    initial begin
        net_polarity = 0;
        forever begin
            @(posedge clk);
            #1 net_polarity = ~net_polarity;
        end
    end

    always @(posedge clk) pol_edge <= net_polarity;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one packet slot per direction, processor-visible registers.
    bit          m_in_full  = 0;
    bit          m_out_full = 0;
    logic [63:0] m_ibuf = '0;
    logic [63:0] m_obuf = '0;
    logic [63:0] m_dout = '0;
    bit          m_so   = 0;
    logic [63:0] m_do   = '0;

    always @(posedge clk or negedge reset) begin
        bit          pin;
        bit          pout;
        logic [63:0] pibuf;
        logic [63:0] pobuf;
        if (!reset) begin
            m_in_full = 0; m_out_full = 0;
            m_ibuf = '0;   m_obuf = '0;
            m_dout = '0;   m_so = 0; m_do = '0;
        end else begin
            pin = m_in_full; pout = m_out_full; pibuf = m_ibuf; pobuf = m_obuf;
            if (nicEn && !nicEnWr) begin
                if (addr == 2'd0) begin
                    m_dout = pibuf;
                    if (pin) m_in_full = 0;
                end else if (addr == 2'd1) m_dout = {63'd0, pin};
                else if (addr == 2'd3)     m_dout = {63'd0, pout};
            end
            if (net_si && !pin) begin
                m_ibuf = net_di;
                m_in_full = 1;
            end
            m_so = pout && net_ro && (net_polarity == pobuf[63]);
            if (m_so) begin
                m_do = pobuf;
                m_out_full = 0;
            end
            if (nicEn && nicEnWr && addr == 2'd2 && !pout) begin
                m_obuf = d_in;
                m_out_full = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (run_cmp) begin
            chk("m_d_out",  d_out,  m_dout);
            chk("m_net_so", {63'd0, net_so}, {63'd0, m_so});
            chk("m_net_do", net_do, m_do);
            chk("m_net_ri", {63'd0, net_ri}, {63'd0, ~m_in_full});
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [63:0] d);
        nicEn = 1; nicEnWr = 1; addr = a; d_in = d;
        tick(1);
        nicEn = 0; nicEnWr = 0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [63:0] v);
        nicEn = 1; nicEnWr = 0; addr = a;
        tick(1);
        nicEn = 0;
        v = d_out;
    endtask

    task automatic wait_so(output bit seen, output logic [63:0] d, output logic pol);
        seen = 0; d = '0; pol = 0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (net_so) begin
                seen = 1; d = net_do; pol = pol_edge;
                break;
            end
        end
    endtask

    initial begin
        logic [63:0] v;
        logic [63:0] d;
        bit          seen;
        logic        pol;
        bit          any_so;

        reset = 1; addr = 0; d_in = '0; nicEn = 0; nicEnWr = 0;
        net_si = 0; net_di = '0; net_ro = 0;
        #1 reset = 0;
        #1 run_cmp = 1;
        tick(2);
        chk("rst_d_out", d_out, 64'd0);
        chk("rst_net_so", {63'd0, net_so}, 64'd0);
        chk("rst_net_do", net_do, 64'd0);
        chk("rst_net_ri", {63'd0, net_ri}, 64'd1);
        reset = 1;
        tick(1);

        // Inject with VC 1: must leave on a cycle following a polarity-1 edge.
        net_ro = 1;
        wr(2'b10, 64'h8000_0000_0000_00A5);
        wait_so(seen, d, pol);
        chk("inj_seen", {63'd0, seen}, 64'd1);
        chk("inj_do", d, 64'h8000_0000_0000_00A5);
        chk("inj_pol", {63'd0, pol}, 64'd1);
        tick(1);
        chk("inj_one_cycle", {63'd0, net_so}, 64'd0);
        rd(2'b11, v);
        chk("inj_status", v, 64'd0);

        // Output blocked by router: second write must be dropped.
        net_ro = 0;
        wr(2'b10, 64'h0000_0000_0000_0077);
        any_so = 0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (net_so) any_so = 1;
        end
        chk("blk_no_so", {63'd0, any_so}, 64'd0);
        rd(2'b11, v);
        chk("blk_status", v, 64'd1);
        wr(2'b10, 64'h1234);
        net_ro = 1;
        wait_so(seen, d, pol);
        chk("blk_seen", {63'd0, seen}, 64'd1);
        chk("blk_do", d, 64'h0000_0000_0000_0077);
        chk("blk_pol", {63'd0, pol}, 64'd0);
        net_ro = 0;
        tick(1);

        // Eject.
        net_si = 1; net_di = 64'hDEAD_BEEF_0000_0001;
        tick(1);
        chk("ej_ri_low", {63'd0, net_ri}, 64'd0);
        net_di = 64'h2;
        tick(2);
        rd(2'b01, v);
        chk("ej_status", v, 64'd1);
        // Read 00 while net_si is still asserted: old packet returned, new one taken next cycle.
        rd(2'b00, v);
        chk("ej_data", v, 64'hDEAD_BEEF_0000_0001);
        chk("ej_ri_after_rd", {63'd0, net_ri}, 64'd1);
        tick(1);
        net_si = 0;
        rd(2'b01, v);
        chk("ej2_status", v, 64'd1);
        rd(2'b00, v);
        chk("ej2_data", v, 64'h2);
        rd(2'b01, v);
        chk("ej_empty", v, 64'd0);
        chk("ej_ri_high", {63'd0, net_ri}, 64'd1);

        // Concurrency: eject, inject and a colliding write in one cycle.
        wr(2'b10, 64'h8000_0000_0000_0055);
        for (int i = 0; i < 4; i++) begin
            if (net_polarity) break;
            tick(1);
        end
        chk("cc_pol_ready", {63'd0, net_polarity}, 64'd1);
        net_ro = 1; net_si = 1; net_di = 64'hCAFE;
        nicEn = 1; nicEnWr = 1; addr = 2'b10; d_in = 64'h9999;
        tick(1);
        nicEn = 0; nicEnWr = 0; net_si = 0; net_ro = 0;
        chk("cc_so", {63'd0, net_so}, 64'd1);
        chk("cc_do", net_do, 64'h8000_0000_0000_0055);
        chk("cc_ri", {63'd0, net_ri}, 64'd0);
        rd(2'b11, v);
        chk("cc_out_status", v, 64'd0);
        rd(2'b00, v);
        chk("cc_ibuf", v, 64'hCAFE);

        // Reset mid-traffic with both buffers full.
        wr(2'b10, 64'h0000_0000_0000_0042);
        net_si = 1; net_di = 64'h77;
        tick(1);
        net_si = 0;
        tick(1);
        #1 reset = 0;
        #1;
        chk("mrst_so", {63'd0, net_so}, 64'd0);
        chk("mrst_ri", {63'd0, net_ri}, 64'd1);
        chk("mrst_d_out", d_out, 64'd0);
        tick(1);
        reset = 1;
        net_ro = 1;
        rd(2'b01, v);
        chk("mrst_in_status", v, 64'd0);
        rd(2'b11, v);
        chk("mrst_out_status", v, 64'd0);
        rd(2'b00, v);
        chk("mrst_ibuf", v, 64'd0);

        // Reset cutting an in-flight inject pulse.
        wr(2'b10, 64'h0000_0000_0000_0011);
        wait_so(seen, d, pol);
        chk("cut_seen", {63'd0, seen}, 64'd1);
        #1 reset = 0;
        #1;
        chk("cut_so", {63'd0, net_so}, 64'd0);
        chk("cut_do", net_do, 64'd0);
        tick(1);
        reset = 1;
        net_ro = 0;
        tick(2);

        run_cmp = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule
